// File: rtl/display_flash_ctrl_if.sv
// Bundle of the blanker's data and control signals between the digit mux side
// and the 7-segment pin side.
interface display_flash_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 7
);
  logic [1:0]            mode;
  logic [NUM_DIGITS-1:0] digit_mask;
  logic                  burst_start;
  logic [3:0]            burst_len;
  logic [NUM_DIGITS-1:0] anode_in;
  logic [SEG_W-1:0]      seg_in;
  logic                  dp_in;
  logic [NUM_DIGITS-1:0] anode;
  logic [SEG_W-1:0]      seg;
  logic                  dp;
  logic                  phase_on;
  logic                  burst_busy;

  modport master (
    output mode, digit_mask, burst_start, burst_len, anode_in, seg_in, dp_in,
    input  anode, seg, dp, phase_on, burst_busy
  );

  modport slave (
    input  mode, digit_mask, burst_start, burst_len, anode_in, seg_in, dp_in,
    output anode, seg, dp, phase_on, burst_busy
  );
endinterface

// File: rtl/display_flash_ctrl.sv
// Clocked display blanker: self-timed slow/fast blink, per-digit masking,
// BLANK override and a counted one-shot flash burst. All outputs registered.
module display_flash_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int SEG_W       = 7,
  parameter int HALF_PERIOD = 25000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_flash_ctrl_if.slave  bus
);

  localparam int DIV_W = $clog2(HALF_PERIOD + 1);
  localparam logic [DIV_W-1:0] LIM_SLOW = DIV_W'(HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0] LIM_FAST = DIV_W'(HALF_PERIOD / 4 - 1);
  localparam logic [1:0] MODE_STEADY = 2'b00;
  localparam logic [1:0] MODE_FAST   = 2'b10;
  localparam logic [1:0] MODE_BLANK  = 2'b11;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e                r_state;
  logic [1:0]            r_mode;
  logic [DIV_W-1:0]      r_div;
  logic                  r_phase;
  logic [3:0]            r_len;
  logic [3:0]            r_cnt;
  logic                  r_busy;
  logic [NUM_DIGITS-1:0] r_anode;
  logic [SEG_W-1:0]      r_seg;
  logic                  r_dp;

  logic [DIV_W-1:0]      w_lim;
  logic                  w_wrap;
  logic [NUM_DIGITS-1:0] w_blank;
  logic [NUM_DIGITS-1:0] w_anode;

  always_comb begin
    w_lim   = (r_state == S_IDLE && r_mode == MODE_FAST) ? LIM_FAST : LIM_SLOW;
    w_wrap  = (r_div == w_lim);
    w_blank = {NUM_DIGITS{~r_phase}} & bus.digit_mask;
    w_anode = bus.anode_in | w_blank;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_STEADY;
      r_div   <= '0;
      r_phase <= 1'b1;
      r_len   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_anode <= '1;
      r_seg   <= '1;
      r_dp    <= 1'b1;
    end else begin
      r_mode <= bus.mode;
      if (r_state == S_IDLE) begin
        if (bus.burst_start && bus.burst_len != 4'd0) begin
          // The start itself is the first on-to-off edge, so the count begins at 1.
          r_state <= S_BURST;
          r_len   <= bus.burst_len;
          r_cnt   <= 4'd1;
          r_div   <= '0;
          r_phase <= 1'b0;
          r_busy  <= 1'b1;
        end else if (bus.mode != r_mode || r_mode == MODE_STEADY || r_mode == MODE_BLANK) begin
          r_div   <= '0;
          r_phase <= 1'b1;
        end else if (w_wrap) begin
          r_div   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end else begin
        if (w_wrap) begin
          r_div <= '0;
          if (r_phase && r_cnt == r_len) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_phase <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_phase <= ~r_phase;
            if (r_phase) r_cnt <= r_cnt + 4'd1;
          end
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end

      // BLANK wins over blinking; an all-off anode also forces segments dark.
      if (bus.mode == MODE_BLANK) begin
        r_anode <= '1;
        r_seg   <= '1;
        r_dp    <= 1'b1;
      end else begin
        r_anode <= w_anode;
        if (&w_anode) begin
          r_seg <= '1;
          r_dp  <= 1'b1;
        end else begin
          r_seg <= bus.seg_in;
          r_dp  <= bus.dp_in;
        end
      end
    end
  end

  assign bus.anode      = r_anode;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.phase_on   = r_phase;
  assign bus.burst_busy = r_busy;

endmodule

// File: tb/tb_display_flash_ctrl.sv
// Randomised and directed bench for display_flash_ctrl against an elapsed-time
// reference model, with literal checks on the test-plan scenarios.
module tb_display_flash_ctrl;

  localparam int ND = 4;
  localparam int SW = 7;
  localparam int HP = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  display_flash_ctrl_if #(.NUM_DIGITS(ND), .SEG_W(SW)) bus ();

  display_flash_ctrl #(.NUM_DIGITS(ND), .SEG_W(SW), .HALF_PERIOD(HP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase derived from cycles elapsed since the current epoch began.
  logic [ND-1:0] e_anode;
  logic [SW-1:0] e_seg;
  logic          e_dp, e_phase, e_busy;
  logic [1:0]    m_mode;
  int            m_t, m_len;

  always @(posedge clk) begin
    logic [ND-1:0] a;
    int lim;
    if (!rst_n) begin
      e_anode = '1; e_seg = '1; e_dp = 1'b1; e_phase = 1'b1; e_busy = 1'b0;
      m_mode = 2'b00; m_t = 0; m_len = 0;
    end else begin
      if (bus.mode == 2'b11) begin
        e_anode = '1; e_seg = '1; e_dp = 1'b1;
      end else begin
        a = bus.anode_in | (e_phase ? 4'b0000 : bus.digit_mask);
        e_anode = a;
        if (a == 4'b1111) begin e_seg = '1; e_dp = 1'b1; end
        else begin e_seg = bus.seg_in; e_dp = bus.dp_in; end
      end
      if (e_busy) begin
        m_t++;
        if (m_t == 2 * HP * m_len) begin
          e_busy = 1'b0; m_t = 0; e_phase = 1'b1;
        end else begin
          e_phase = ((m_t / HP) % 2) == 1;
        end
      end else if (bus.burst_start && bus.burst_len != 0) begin
        e_busy = 1'b1; m_t = 0; e_phase = 1'b0; m_len = int'(bus.burst_len);
      end else if (bus.mode != m_mode || bus.mode == 2'b00 || bus.mode == 2'b11) begin
        m_t = 0; e_phase = 1'b1;
      end else begin
        m_t++;
        lim = (bus.mode == 2'b01) ? HP : HP / 4;
        e_phase = ((m_t / lim) % 2) == 0;
      end
      m_mode = bus.mode;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_anode", 32'(bus.anode), 32'(e_anode));
      chk("model_seg", 32'(bus.seg), 32'(e_seg));
      chk("model_dp", 32'(bus.dp), 32'(e_dp));
      chk("model_phase", 32'(bus.phase_on), 32'(e_phase));
      chk("model_busy", 32'(bus.burst_busy), 32'(e_busy));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt, tog, run;
    logic prev;

    rst_n = 1'b0;
    bus.mode = 2'b00; bus.digit_mask = 4'b0001; bus.burst_start = 1'b0;
    bus.burst_len = 4'd0; bus.anode_in = 4'b1110; bus.seg_in = 7'h40; bus.dp_in = 1'b0;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    chk("rst_anode", 32'(bus.anode), 32'h0000000F);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'd1);
    chk("rst_phase", 32'(bus.phase_on), 32'd1);
    chk("rst_busy", 32'(bus.burst_busy), 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("steady_anode", 32'(bus.anode), 32'h0000000E);
    chk("steady_seg", 32'(bus.seg), 32'h40);

    // SLOW blink: one digit blinks 8 on / 8 off.
    bus.mode = 2'b01;
    tick(2);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (bus.anode == 4'b1110 && bus.seg == 7'h40) cnt++;
    end
    chk("slow_visible_cycles", 32'(cnt), 32'd16);
    bus.anode_in = 4'b1101;
    tick(1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (bus.anode == 4'b1101) cnt++;
    end
    chk("slow_unmasked_digit", 32'(cnt), 32'd16);

    // FAST blink toggles every 2 cycles; switching to SLOW restarts a full on-phase.
    bus.mode = 2'b10; bus.digit_mask = 4'b1111;
    tick(3);
    prev = bus.phase_on; tog = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (bus.phase_on != prev) tog++;
      prev = bus.phase_on;
    end
    chk("fast_toggles", 32'(tog), 32'd8);
    tick(1);
    bus.mode = 2'b01;
    run = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.phase_on && run == i) run++;
    end
    chk("slow_full_on_after_switch", 32'(run), 32'd8);

    // Burst of 3 in STEADY with an ignored second request.
    bus.mode = 2'b00;
    tick(2);
    bus.burst_start = 1'b1; bus.burst_len = 4'd3;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (i == 0) bus.burst_start = 1'b0;
      if (i == 10) begin bus.burst_start = 1'b1; bus.burst_len = 4'd5; end
      if (i == 11) bus.burst_start = 1'b0;
      if (bus.burst_busy) cnt++;
    end
    chk("burst_busy_cycles", 32'(cnt), 32'd48);
    chk("burst_end_phase", 32'(bus.phase_on), 32'd1);
    chk("burst_end_busy", 32'(bus.burst_busy), 32'd0);

    // BLANK during a burst hides the display but the burst keeps its timing.
    bus.burst_start = 1'b1; bus.burst_len = 4'd3;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (i == 0) bus.burst_start = 1'b0;
      if (i == 5) bus.mode = 2'b11;
      if (i == 20) begin
        chk("blank_anode", 32'(bus.anode), 32'h0000000F);
        chk("blank_seg", 32'(bus.seg), 32'h7F);
        chk("blank_dp", 32'(bus.dp), 32'd1);
      end
      if (bus.burst_busy) cnt++;
    end
    chk("blank_burst_cycles", 32'(cnt), 32'd48);

    // burst_len = 0 is ignored.
    bus.mode = 2'b00;
    tick(2);
    bus.burst_start = 1'b1; bus.burst_len = 4'd0;
    tick(1);
    bus.burst_start = 1'b0;
    tick(1);
    chk("len0_busy", 32'(bus.burst_busy), 32'd0);
    chk("len0_phase", 32'(bus.phase_on), 32'd1);

    // Reset mid-burst abandons it.
    bus.burst_start = 1'b1; bus.burst_len = 4'd4;
    tick(1);
    bus.burst_start = 1'b0;
    tick(19);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_busy", 32'(bus.burst_busy), 32'd0);
    chk("midrst_phase", 32'(bus.phase_on), 32'd1);
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick(1);
      rst_n = ($urandom_range(0, 699) != 0);
      if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.digit_mask = 4'($urandom);
      bus.anode_in    = 4'($urandom);
      bus.seg_in      = 7'($urandom);
      bus.dp_in       = 1'($urandom);
      bus.burst_start = ($urandom_range(0, 59) == 0);
      bus.burst_len   = 4'($urandom_range(0, 3));
    end
    rst_n = 1'b1;
    tick(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
